imem_loader: RTL

Program loader that fills the instruction memory through its write port from a byte stream, the writer side of the instruction fetch path. It holds the processor core in reset while a program image is loaded, assembles little-endian 32-bit instruction words, writes them at consecutive word addresses starting at 0, and verifies an XOR checksum. When the image is good, it releases the core so fetch begins at pc = 0.

---
 rtl/imem_loader_if.sv | 27 ++
 rtl/imem_loader.sv | 139 +++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and core-control signals of the program loader.
// The master modport is the loader's view; the slave modport is the stream source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, err
  );

  modport slave (
    output start, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: parses a counted little-endian byte image, writes words to instruction memory,
// verifies an XOR checksum and holds the core in reset until a good image has been loaded.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.master bus
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CHK, DONE, ERR} state_t;

  localparam logic [16:0] DEPTH_MAX = 17'(DEPTH);

  state_t            state_reg, state_next;
  logic [15:0]       count_reg, count_next;
  logic [15:0]       word_cnt_reg, word_cnt_next;
  logic [1:0]        byte_cnt_reg, byte_cnt_next;
  logic [31:0]       word_reg, word_next;
  logic [7:0]        csum_reg, csum_next;
  logic              imem_we_reg, imem_we_next;
  logic [ADDR_W-1:0] imem_addr_reg, imem_addr_next;
  logic [31:0]       imem_wdata_reg, imem_wdata_next;

  logic        ready;
  logic        accept;
  logic [15:0] hdr_count;
  logic        hdr_bad;
  logic [31:0] word_lane;

  assign ready = (state_reg == HDR0) || (state_reg == HDR1) ||
                 (state_reg == DATA) || (state_reg == CHK);
  assign accept    = bus.in_valid && ready;
  assign hdr_count = {bus.in_data, count_reg[7:0]};
  assign hdr_bad   = (hdr_count == 16'd0) || ({1'b0, hdr_count} > DEPTH_MAX);

  // Incoming byte lands in the lane selected by the byte counter; other lanes keep earlier bytes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign word_lane[gi*8 +: 8] = (byte_cnt_reg == 2'(gi)) ? bus.in_data : word_reg[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    word_cnt_next   = word_cnt_reg;
    byte_cnt_next   = byte_cnt_reg;
    word_next       = word_reg;
    csum_next       = csum_reg;
    imem_we_next    = 1'b0;
    imem_addr_next  = imem_addr_reg;
    imem_wdata_next = imem_wdata_reg;

    case (state_reg)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          state_next    = HDR0;
          count_next    = 16'd0;
          word_cnt_next = 16'd0;
          byte_cnt_next = 2'd0;
          word_next     = 32'd0;
          csum_next     = 8'd0;
        end
      end
      HDR0: begin
        if (accept) begin
          count_next = {count_reg[15:8], bus.in_data};
          state_next = HDR1;
        end
      end
      HDR1: begin
        if (accept) begin
          count_next = hdr_count;
          state_next = hdr_bad ? ERR : DATA;
        end
      end
      DATA: begin
        if (accept) begin
          csum_next     = csum_reg ^ bus.in_data;
          word_next     = word_lane;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            imem_we_next    = 1'b1;
            imem_addr_next  = word_cnt_reg[ADDR_W-1:0];
            imem_wdata_next = word_lane;
            word_cnt_next   = word_cnt_reg + 16'd1;
            if (word_cnt_reg + 16'd1 == count_reg) begin
              state_next = CHK;
            end
          end
        end
      end
      CHK: begin
        if (accept) begin
          state_next = (bus.in_data == csum_reg) ? DONE : ERR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      count_reg      <= 16'd0;
      word_cnt_reg   <= 16'd0;
      byte_cnt_reg   <= 2'd0;
      word_reg       <= 32'd0;
      csum_reg       <= 8'd0;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= 32'd0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      word_cnt_reg   <= word_cnt_next;
      byte_cnt_reg   <= byte_cnt_next;
      word_reg       <= word_next;
      csum_reg       <= csum_next;
      imem_we_reg    <= imem_we_next;
      imem_addr_reg  <= imem_addr_next;
      imem_wdata_reg <= imem_wdata_next;
    end
  end

  // The core is released only while a verified image is resident.
  assign bus.core_rst   = (state_reg != DONE);
  assign bus.in_ready   = ready;
  assign bus.busy       = ready;
  assign bus.done       = (state_reg == DONE);
  assign bus.err        = (state_reg == ERR);
  assign bus.imem_we    = imem_we_reg;
  assign bus.imem_addr  = imem_addr_reg;
  assign bus.imem_wdata = imem_wdata_reg;

endmodule
